// File: rtl/jump_arc_controller.sv
// Jump arc controller: a debounced button press launches a rise / hang / fall height trajectory.
// Define JUMP_BUFFER_EN to chain a press made during FALL straight into the next jump.
module jump_arc_controller #(
    parameter int unsigned HEIGHT_W        = 6,
    parameter int unsigned MAX_HEIGHT      = 24,
    parameter int unsigned STEP_CYCLES     = 270_000,
    parameter int unsigned HANG_STEPS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 270_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn1,
    input  logic                freeze,
    output logic [HEIGHT_W-1:0] height,
    output logic                airborne,
    output logic                landed
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HangW = (HANG_STEPS > 1) ? $clog2(HANG_STEPS) : 1;

    localparam logic [StepW-1:0]    StepLast = StepW'(STEP_CYCLES - 1);
    localparam logic [DbW-1:0]      DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HangW-1:0]    HangLast = HangW'((HANG_STEPS > 0) ? HANG_STEPS - 1 : 0);
    localparam logic [HEIGHT_W-1:0] MaxH     = HEIGHT_W'(MAX_HEIGHT);
    localparam logic [HEIGHT_W-1:0] OneH     = HEIGHT_W'(1);

    typedef enum logic [1:0] {StIdle, StRise, StHang, StFall} state_e;

    logic           sync1_q, sync2_q;
    logic           db_level_q, db_prev_q;
    logic [DbW-1:0] db_cnt_q;
    logic           warm_q, armed_q;
    logic           press;

    // armed_q blocks presses until a real release is seen after reset, so a button
    // held through reset cannot launch a jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
            db_cnt_q   <= '0;
            warm_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync1_q   <= btn1;
            sync2_q   <= sync1_q;
            db_prev_q <= db_level_q;
            warm_q    <= 1'b1;
            if (warm_q && sync1_q && sync2_q) begin
                armed_q <= 1'b1;
            end
            if (sync2_q == db_level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DbLast) begin
                db_level_q <= sync2_q;
                db_cnt_q   <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign press = armed_q & db_prev_q & ~db_level_q;

    state_e              state_q, state_d;
    logic [HEIGHT_W-1:0] height_q, height_d;
    logic [StepW-1:0]    step_q, step_d;
    logic [HangW-1:0]    hang_q, hang_d;
    logic                landed_q, landed_d;
    logic                tick, land_tick, chain;

    assign tick      = (step_q == StepLast);
    assign land_tick = (state_q == StFall) && tick && (height_q == OneH);

`ifdef JUMP_BUFFER_EN
    logic buf_q, buf_d;

    always_comb begin
        buf_d = buf_q;
        if (!freeze && state_q == StFall) begin
            if (land_tick) begin
                buf_d = 1'b0;
            end else if (press) begin
                buf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
        end
    end

    // A press on the landing cycle itself also chains.
    assign chain = buf_q | press;
`else
    assign chain = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        step_d   = step_q;
        hang_d   = hang_q;
        landed_d = 1'b0;
        if (!freeze) begin
            if (state_q != StIdle) begin
                step_d = tick ? '0 : step_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (press) begin
                        state_d  = StRise;
                        step_d   = '0;
                        height_d = '0;
                    end
                end
                StRise: begin
                    if (tick) begin
                        height_d = height_q + 1'b1;
                        if (height_d == MaxH) begin
                            state_d = (HANG_STEPS == 0) ? StFall : StHang;
                            hang_d  = '0;
                        end
                    end
                end
                StHang: begin
                    if (tick) begin
                        if (hang_q == HangLast) begin
                            state_d = StFall;
                        end else begin
                            hang_d = hang_q + 1'b1;
                        end
                    end
                end
                StFall: begin
                    if (tick) begin
                        height_d = height_q - 1'b1;
                        if (land_tick) begin
                            landed_d = 1'b1;
                            state_d  = chain ? StRise : StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            height_q <= '0;
            step_q   <= '0;
            hang_q   <= '0;
            landed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            step_q   <= step_d;
            hang_q   <= hang_d;
            landed_q <= landed_d;
        end
    end

    assign height   = height_q;
    assign airborne = (state_q != StIdle);
    assign landed   = landed_q;

endmodule

// File: tb/tb_jump_arc_controller.sv
// Directed bench for jump_arc_controller with small parameters; a second instance has no hang.
`timescale 1ns/1ps
module tb_jump_arc_controller;

    localparam int unsigned HW = 4;

    logic          clk = 1'b0;
    logic          rst, btn1, btn1_nh, freeze;
    logic [HW-1:0] height, height_nh;
    logic          airborne, airborne_nh, landed, landed_nh;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    jump_arc_controller #(
        .HEIGHT_W(4), .MAX_HEIGHT(3), .STEP_CYCLES(2), .HANG_STEPS(2), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .btn1(btn1), .freeze(freeze),
        .height(height), .airborne(airborne), .landed(landed)
    );

    jump_arc_controller #(
        .HEIGHT_W(4), .MAX_HEIGHT(3), .STEP_CYCLES(2), .HANG_STEPS(0), .DEBOUNCE_CYCLES(4)
    ) dut_nh (
        .clk(clk), .rst(rst), .btn1(btn1_nh), .freeze(freeze),
        .height(height_nh), .airborne(airborne_nh), .landed(landed_nh)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Press and count edges (first low-sampling edge = 1) until the main DUT is airborne.
    task automatic launch(output int n);
        btn1 = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!airborne && n < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1; btn1 = 1'b1; btn1_nh = 1'b1; freeze = 1'b0;
        repeat (3) cyc();
        total++; if (height !== 4'd0) $display("FAIL reset_height: got %0d want 0", height);
        if (height !== 4'd0) bad++;
        total++; if (airborne !== 1'b0) begin bad++; $display("FAIL reset_airborne: got %b want 0", airborne); end
        total++; if (landed !== 1'b0) begin bad++; $display("FAIL reset_landed: got %b want 0", landed); end
        rst = 1'b0;
        repeat (5) cyc();
        total++; if (airborne_nh !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 0", airborne_nh); end
    endtask

    task automatic test_basic_jump();
        int n;
        int exp_h[16] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0};
        logic seen;
        launch(n);
        total++; if (n !== 7) begin bad++; $display("FAIL launch_latency: got %0d want 7", n); end
        total++; if (height !== 4'd0) begin bad++; $display("FAIL rise_entry_height: got %0d want 0", height); end
        for (int k = 0; k < 16; k++) begin
            cyc();
            total++;
            if (int'(height) !== exp_h[k]) begin
                bad++; $display("FAIL arc_height[%0d]: got %0d want %0d", k + 1, height, exp_h[k]);
            end
            total++;
            if (landed !== (k == 15)) begin
                bad++; $display("FAIL arc_landed[%0d]: got %b want %b", k + 1, landed, k == 15);
            end
        end
        total++; if (airborne !== 1'b0) begin bad++; $display("FAIL land_airborne: got %b want 0", airborne); end
        seen = 1'b0;
        repeat (30) begin
            cyc();
            seen |= airborne | landed;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL held_no_rejump: got %b want 0", seen); end
        btn1 = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic test_glitch();
        logic seen;
        btn1 = 1'b0;
        repeat (3) cyc();
        btn1 = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            cyc();
            seen |= airborne;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_3clk: got %b want 0", seen); end
    endtask

    task automatic test_debounce_edge();
        int n;
        btn1 = 1'b0;
        repeat (4) cyc();
        btn1 = 1'b1;
        n = 4;
        while (!airborne && n < 20) begin
            cyc();
            n++;
        end
        total++; if (n !== 7) begin bad++; $display("FAIL low_4clk_latency: got %0d want 7", n); end
        n = 0;
        while (!landed && n < 40) begin
            cyc();
            n++;
        end
        total++; if (n !== 16) begin bad++; $display("FAIL low_4clk_duration: got %0d want 16", n); end
        repeat (10) cyc();
    endtask

    task automatic test_freeze();
        int n;
        logic hold_bad;
        launch(n);
        btn1 = 1'b1;
        repeat (4) cyc();
        total++; if (height !== 4'd2) begin bad++; $display("FAIL pre_freeze_height: got %0d want 2", height); end
        freeze = 1'b1;
        hold_bad = 1'b0;
        repeat (10) begin
            cyc();
            hold_bad |= (height !== 4'd2) | landed | ~airborne;
        end
        freeze = 1'b0;
        total++; if (hold_bad !== 1'b0) begin bad++; $display("FAIL freeze_hold: got %b want 0", hold_bad); end
        n = 14;
        while (!landed && n < 60) begin
            cyc();
            n++;
        end
        total++; if (n !== 26) begin bad++; $display("FAIL freeze_duration: got %0d want 26", n); end
        repeat (10) cyc();
    endtask

    task automatic test_freeze_press();
        logic seen;
        freeze = 1'b1;
        btn1 = 1'b0;
        repeat (10) cyc();
        freeze = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            cyc();
            seen |= airborne;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL frozen_press_dropped: got %b want 0", seen); end
        btn1 = 1'b1;
        repeat (10) cyc();
    endtask

    task automatic test_reset_mid_jump();
        int n;
        logic seen;
        launch(n);
        n = 0;
        while (height !== 4'd3 && n < 12) begin
            cyc();
            n++;
        end
        total++; if (height !== 4'd3) begin bad++; $display("FAIL reach_apex: got %0d want 3", height); end
        rst = 1'b1;
        cyc();
        total++; if (height !== 4'd0) begin bad++; $display("FAIL midreset_height: got %0d want 0", height); end
        total++; if (airborne !== 1'b0) begin bad++; $display("FAIL midreset_airborne: got %b want 0", airborne); end
        total++; if (landed !== 1'b0) begin bad++; $display("FAIL midreset_landed: got %b want 0", landed); end
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            cyc();
            seen |= airborne;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL held_across_reset: got %b want 0", seen); end
        btn1 = 1'b1;
        repeat (10) cyc();
        launch(n);
        btn1 = 1'b1;
        total++; if (n !== 7) begin bad++; $display("FAIL rearm_latency: got %0d want 7", n); end
        n = 0;
        while (!landed && n < 40) begin
            cyc();
            n++;
        end
        repeat (10) cyc();
    endtask

    task automatic test_fall_press();
        int n;
        logic seen;
        launch(n);
        btn1 = 1'b1;
        repeat (6) cyc();
        btn1 = 1'b0;
        repeat (6) cyc();
        btn1 = 1'b1;
        total++; if (height !== 4'd2) begin bad++; $display("FAIL fall_window_height: got %0d want 2", height); end
        n = 0;
        while (!landed && n < 20) begin
            cyc();
            n++;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL fall_land_time: got %0d want 4", n); end
`ifdef JUMP_BUFFER_EN
        total++; if (airborne !== 1'b1 || height !== 4'd0) begin
            bad++; $display("FAIL buffered_rise: got air=%b h=%0d want air=1 h=0", airborne, height);
        end
        repeat (2) cyc();
        total++; if (height !== 4'd1) begin bad++; $display("FAIL buffered_climb: got %0d want 1", height); end
        n = 2;
        while (!landed && n < 40) begin
            cyc();
            n++;
        end
        total++; if (n !== 16 || airborne !== 1'b0) begin
            bad++; $display("FAIL buffered_second_land: got t=%0d air=%b want t=16 air=0", n, airborne);
        end
`else
        total++; if (airborne !== 1'b0) begin bad++; $display("FAIL unbuffered_idle: got %b want 0", airborne); end
        seen = 1'b0;
        repeat (20) begin
            cyc();
            seen |= airborne;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL unbuffered_no_jump: got %b want 0", seen); end
`endif
        repeat (10) cyc();
    endtask

    task automatic test_no_hang();
        int n;
        int exp_h[12] = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
        btn1_nh = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!airborne_nh && n < 20);
        btn1_nh = 1'b1;
        total++; if (n !== 7) begin bad++; $display("FAIL nohang_latency: got %0d want 7", n); end
        for (int k = 0; k < 12; k++) begin
            cyc();
            total++;
            if (int'(height_nh) !== exp_h[k] || landed_nh !== (k == 11)) begin
                bad++;
                $display("FAIL nohang_arc[%0d]: got h=%0d l=%b want h=%0d l=%b",
                         k + 1, height_nh, landed_nh, exp_h[k], k == 11);
            end
        end
        total++; if (airborne !== 1'b0) begin bad++; $display("FAIL main_unaffected: got %b want 0", airborne); end
    endtask

    initial begin
        test_reset();
        test_basic_jump();
        test_glitch();
        test_debounce_edge();
        test_freeze();
        test_freeze_press();
        test_reset_mid_jump();
        test_fall_press();
        test_no_hang();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jump_arc_controller.md
JUMP_ARC_CONTROLLER -- requirements
Module: jump_arc_controller

Interface
REQ-001 Parameter HEIGHT_W, default 6, SHALL be the bit width of the height output.
REQ-002 Parameter MAX_HEIGHT, default 24, SHALL be the apex height in steps; legal range is 1 to 2^HEIGHT_W-1.
REQ-003 Parameter STEP_CYCLES, default 270_000, SHALL be the clocks per height step (at least 1).
REQ-004 Parameter HANG_STEPS, default 4, SHALL be the number of steps held at apex; 0 means no hang.
REQ-005 Parameter DEBOUNCE_CYCLES, default 270_000, SHALL be the number of consecutive stable clocks required to accept a button level (at least 1).
REQ-006 Port clk, input, 1 bit, SHALL be the single clock for all logic.
REQ-007 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-008 Port btn1, input, 1 bit, SHALL be the asynchronous, active-low jump button.
REQ-009 Port freeze, input, 1 bit, SHALL, when high, hold the state, height and step counter (game paused or over).
REQ-010 Port height, output, HEIGHT_W bits, SHALL carry the current sprite lift above ground.
REQ-011 Port airborne, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-012 Port landed, output, 1 bit, SHALL be a one-clock pulse on the FALL to IDLE transition.

Function
REQ-013 btn1 SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 Debounce:
- The debounced level is initialised to 1 (released).
- The counter increments while the synchronised level differs from the debounced level, and clears when they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the debounced level updates and the counter clears.
REQ-015 press SHALL be an internal one-clock pulse on each debounced 1-to-0 transition; holding the button SHALL NOT generate further presses.
REQ-016 FSM states SHALL be IDLE, RISE, HANG and FALL.
REQ-017 IDLE with press and not freeze SHALL go to RISE on the next clock, with the step counter cleared and height remaining 0.
REQ-018 The step counter SHALL count 0 to STEP_CYCLES-1 in RISE, HANG and FALL, raising tick at STEP_CYCLES-1 and then wrapping to 0.
REQ-019 RISE on tick SHALL increment height; when height reaches MAX_HEIGHT, go to HANG, or to FALL if HANG_STEPS is 0.
REQ-020 HANG SHALL count HANG_STEPS ticks with height held at MAX_HEIGHT, then go to FALL.
REQ-021 FALL on tick SHALL decrement height; the tick that sets height to 0 SHALL enter IDLE and assert landed in that same cycle.
REQ-022 height SHALL never exceed MAX_HEIGHT and SHALL never underflow below 0.
REQ-023 A press while airborne SHALL be ignored, except as allowed by REQ-030.
REQ-024 While freeze is high:
- the FSM, height and step counter SHALL hold;
- the debouncer SHALL keep running;
- a press occurring while frozen SHALL be discarded;
- landed SHALL stay 0.
REQ-025 If freeze and a press occur in the same cycle, freeze SHALL win and the press SHALL be discarded.
REQ-026 Total jump duration SHALL be (2*MAX_HEIGHT+HANG_STEPS)*STEP_CYCLES clocks from RISE entry to IDLE entry, excluding frozen cycles.

Reset
REQ-027 While rst is high, the following SHALL take effect at the next clock edge, including mid-jump:
- state = IDLE, height = 0, airborne = 0, landed = 0;
- step and debounce counters = 0;
- synchroniser flops and debounced level = 1;
- jump buffer cleared.
REQ-028 A low level on btn1 present when rst deasserts SHALL NOT cause a jump until the button is released and pressed again.

Configuration
REQ-029 Macro JUMP_BUFFER_EN SHALL compile a 1-bit jump buffer in or out.
REQ-030 With JUMP_BUFFER_EN defined:
- a press during FALL SHALL set the buffer;
- on landing, the FSM SHALL go directly to RISE instead of IDLE, with landed still pulsing and the buffer clearing;
- presses during RISE and HANG SHALL remain ignored.
REQ-031 Without JUMP_BUFFER_EN, no buffer logic SHALL exist, and presses during FALL SHALL be ignored.

Verification
Parameters for all scenarios: HEIGHT_W=4, MAX_HEIGHT=3, STEP_CYCLES=2, HANG_STEPS=2, DEBOUNCE_CYCLES=4.
REQ-032 Scenario 1 (basic jump):
- Stimulus: hold btn1 low.
- Response: airborne rises 2+4+1 clocks after the first low sample.
- Response: height goes 1,2,3 at 2-clock spacing, holds 3 for 4 clocks, then goes 2,1,0.
- Response: landed pulses once, 16 clocks after RISE entry; no second jump while held.
REQ-033 Scenario 2 (glitch rejection): a 3-clock low glitch on btn1 -> no press, airborne stays 0.
REQ-034 Scenario 3 (freeze): assert freeze for 10 clocks while height=2 in RISE -> height stays 2 for 10 clocks, and the trajectory resumes with total duration 16+10.
REQ-035 Scenario 4 (reset mid-jump): rst pulsed while height=3 -> next clock height=0, airborne=0, landed=0; a low btn1 held across reset gives no jump.
REQ-036 Scenario 5 (press during FALL):
- Stimulus: press during FALL at height=2.
- Response with JUMP_BUFFER_EN: landed pulses and the next clock is RISE with height 0.
- Response without JUMP_BUFFER_EN: IDLE after landing.
REQ-037 Scenario 6 (no hang): HANG_STEPS=0 -> height goes 1,2,3,2,1,0 with no hold, total 12 clocks.
